// File: rtl/arm_dp_pkg.sv
// Shared encodings for the ARM data-processing operand stage: instruction field positions,
// opcode constants, shifter control codes and the ID/EX payload layout.
package arm_dp_pkg;

  typedef enum logic [2:0] {
    LSL_I = 3'b000,
    LSL_R = 3'b001,
    LSR_I = 3'b010,
    LSR_R = 3'b011,
    ASR_I = 3'b100,
    ASR_R = 3'b101,
    ROR_I = 3'b110,
    ROR_R = 3'b111
  } shift_ctrl_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_e;

  localparam int COND_LSB   = 28;
  localparam int CLASS_LSB  = 26;
  localparam int I_BIT      = 25;
  localparam int OPC_LSB    = 21;
  localparam int S_BIT      = 20;
  localparam int RN_LSB     = 16;
  localparam int RD_LSB     = 12;
  localparam int RS_LSB     = 8;
  localparam int SHAMT_LSB  = 7;
  localparam int STYPE_LSB  = 5;
  localparam int RSHIFT_BIT = 4;
  localparam int RM_LSB     = 0;

  localparam logic [3:0]  OPC_MOV = 4'hD;
  localparam logic [3:0]  OPC_MVN = 4'hF;
  localparam logic [3:0]  R_PC    = 4'hF;

  localparam logic [31:0] PC_OFFSET_DEF    = 32'd8;
  localparam logic [31:0] PC_OFFSET_RS_DEF = 32'd12;

  typedef struct packed {
    logic [3:0]  cond;
    logic [3:0]  opcode;
    logic        set_flags;
    logic [3:0]  rd;
    logic [31:0] rn_data;
    logic        illegal;
    logic [31:0] rm_data;
    logic [7:0]  imm8;
    logic        imm_or_reg;
    logic [2:0]  shift_control;
    logic [4:0]  shamt_imm;
    logic [7:0]  rs_low;
    logic [3:0]  rotation;
  } id_ex_t;

endpackage

// File: rtl/operand_forward_mux.sv
// Resolves one source operand: PC substitution first, then EX forwarding (non-load),
// then WB forwarding, then the register file.
module operand_forward_mux
  import arm_dp_pkg::*;
#(
  parameter logic [31:0] PC_OFFSET    = PC_OFFSET_DEF,
  parameter logic [31:0] PC_OFFSET_RS = PC_OFFSET_RS_DEF
) (
  input  logic [3:0]  addr,
  input  logic        reg_shift_form,
  input  logic [31:0] pc,
  input  logic        ex_valid,
  input  logic        ex_is_load,
  input  logic [3:0]  ex_addr,
  input  logic [31:0] ex_data,
  input  logic        wb_valid,
  input  logic [3:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic [31:0] rf_data,
  output logic [31:0] operand
);

  // r15 reads bypass forwarding entirely; the PC value seen depends on the shift form.
  always_comb begin
    operand = rf_data;
    if (addr == R_PC) begin
      operand = pc + (reg_shift_form ? PC_OFFSET_RS : PC_OFFSET);
    end else if (ex_valid && !ex_is_load && (ex_addr == addr)) begin
      operand = ex_data;
    end else if (wb_valid && (wb_addr == addr)) begin
      operand = wb_data;
    end
  end

endmodule

// File: rtl/dp_operand_stage.sv
// ARM data-processing decode/operand-fetch stage: reads Rn/Rm/Rs with forwarding, detects
// load-use hazards and holds shifter/ALU fields in a single ID/EX register.
module dp_operand_stage
  import arm_dp_pkg::*;
#(
  parameter logic [31:0] PC_OFFSET    = PC_OFFSET_DEF,
  parameter logic [31:0] PC_OFFSET_RS = PC_OFFSET_RS_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic [3:0]  rf_raddr_n,
  output logic [3:0]  rf_raddr_m,
  output logic [3:0]  rf_raddr_s,
  input  logic [31:0] rf_rdata_n,
  input  logic [31:0] rf_rdata_m,
  input  logic [31:0] rf_rdata_s,
  input  logic        fwd_ex_valid,
  input  logic        fwd_ex_is_load,
  input  logic [3:0]  fwd_ex_addr,
  input  logic [31:0] fwd_ex_data,
  input  logic        fwd_wb_valid,
  input  logic [3:0]  fwd_wb_addr,
  input  logic [31:0] fwd_wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_cond,
  output logic [3:0]  out_opcode,
  output logic        out_set_flags,
  output logic [3:0]  out_rd,
  output logic [31:0] out_rn_data,
  output logic        out_illegal,
  output logic        sh_enable,
  output logic [31:0] sh_in_data,
  output logic [7:0]  sh_in_data_imm,
  output logic        sh_imm_or_reg,
  output logic [2:0]  sh_shift_control,
  output logic [4:0]  sh_shift_amt_imm,
  output logic [31:0] sh_shift_amt_reg,
  output logic [3:0]  sh_rotation_code
);

  logic         imm_form;
  logic         reg_shift_form;
  logic [3:0]   opcode;
  logic         uses_rn;
  logic         uses_rm;
  logic         uses_rs;
  logic         stall;
  logic         capture;
  logic [31:0]  rn_data;
  logic [31:0]  rm_data;
  logic [31:0]  rs_data;
  logic         unused_rs_hi;

  stage_state_e state_d, state_q;
  id_ex_t       payload_d, payload_q;

  assign imm_form       = in_instr[I_BIT];
  assign reg_shift_form = !imm_form && in_instr[RSHIFT_BIT];
  assign opcode         = in_instr[OPC_LSB +: 4];

  assign rf_raddr_n = in_instr[RN_LSB +: 4];
  assign rf_raddr_m = in_instr[RM_LSB +: 4];
  assign rf_raddr_s = in_instr[RS_LSB +: 4];

  operand_forward_mux #(.PC_OFFSET(PC_OFFSET), .PC_OFFSET_RS(PC_OFFSET_RS)) u_mux_rn (
    .addr(rf_raddr_n), .reg_shift_form(reg_shift_form), .pc(in_pc),
    .ex_valid(fwd_ex_valid), .ex_is_load(fwd_ex_is_load), .ex_addr(fwd_ex_addr),
    .ex_data(fwd_ex_data), .wb_valid(fwd_wb_valid), .wb_addr(fwd_wb_addr),
    .wb_data(fwd_wb_data), .rf_data(rf_rdata_n), .operand(rn_data)
  );

  operand_forward_mux #(.PC_OFFSET(PC_OFFSET), .PC_OFFSET_RS(PC_OFFSET_RS)) u_mux_rm (
    .addr(rf_raddr_m), .reg_shift_form(reg_shift_form), .pc(in_pc),
    .ex_valid(fwd_ex_valid), .ex_is_load(fwd_ex_is_load), .ex_addr(fwd_ex_addr),
    .ex_data(fwd_ex_data), .wb_valid(fwd_wb_valid), .wb_addr(fwd_wb_addr),
    .wb_data(fwd_wb_data), .rf_data(rf_rdata_m), .operand(rm_data)
  );

  operand_forward_mux #(.PC_OFFSET(PC_OFFSET), .PC_OFFSET_RS(PC_OFFSET_RS)) u_mux_rs (
    .addr(rf_raddr_s), .reg_shift_form(reg_shift_form), .pc(in_pc),
    .ex_valid(fwd_ex_valid), .ex_is_load(fwd_ex_is_load), .ex_addr(fwd_ex_addr),
    .ex_data(fwd_ex_data), .wb_valid(fwd_wb_valid), .wb_addr(fwd_wb_addr),
    .wb_data(fwd_wb_data), .rf_data(rf_rdata_s), .operand(rs_data)
  );

  // Only the low byte of Rs drives the shifter.
  assign unused_rs_hi = ^rs_data[31:8];

  // Load-use hazard only on sources the instruction actually reads.
  assign uses_rn = !((opcode == OPC_MOV) || (opcode == OPC_MVN));
  assign uses_rm = !imm_form;
  assign uses_rs = reg_shift_form;
  assign stall   = fwd_ex_valid && fwd_ex_is_load && in_valid &&
                   ((uses_rn && (fwd_ex_addr == rf_raddr_n)) ||
                    (uses_rm && (fwd_ex_addr == rf_raddr_m)) ||
                    (uses_rs && (fwd_ex_addr == rf_raddr_s)));

  assign out_valid = (state_q == ST_FULL);
  assign in_ready  = rst_n && (!out_valid || out_ready) && !stall && !flush;
  assign capture   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (capture) state_d = ST_FULL;
      ST_FULL:  if (flush || (out_ready && !capture)) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    payload_d = payload_q;
    if (capture) begin
      payload_d.cond          = in_instr[COND_LSB +: 4];
      payload_d.opcode        = opcode;
      payload_d.set_flags     = in_instr[S_BIT];
      payload_d.rd            = in_instr[RD_LSB +: 4];
      payload_d.rn_data       = rn_data;
      payload_d.illegal       = (in_instr[CLASS_LSB +: 2] != 2'b00);
      payload_d.rm_data       = rm_data;
      payload_d.imm8          = in_instr[7:0];
      payload_d.imm_or_reg    = imm_form;
      payload_d.shift_control = {in_instr[STYPE_LSB +: 2], in_instr[RSHIFT_BIT]};
      payload_d.shamt_imm     = in_instr[SHAMT_LSB +: 5];
      payload_d.rs_low        = rs_data[7:0];
      payload_d.rotation      = in_instr[RS_LSB +: 4];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      payload_q <= '0;
    end else begin
      state_q   <= state_d;
      payload_q <= payload_d;
    end
  end

  assign out_cond         = payload_q.cond;
  assign out_opcode       = payload_q.opcode;
  assign out_set_flags    = payload_q.set_flags;
  assign out_rd           = payload_q.rd;
  assign out_rn_data      = payload_q.rn_data;
  assign out_illegal      = payload_q.illegal;
  assign sh_enable        = out_valid;
  assign sh_in_data       = payload_q.rm_data;
  assign sh_in_data_imm   = payload_q.imm8;
  assign sh_imm_or_reg    = payload_q.imm_or_reg;
  assign sh_shift_control = payload_q.shift_control;
  assign sh_shift_amt_imm = payload_q.shamt_imm;
  assign sh_shift_amt_reg = {24'b0, payload_q.rs_low};
  assign sh_rotation_code = payload_q.rotation;

endmodule

// File: tb/tb_dp_operand_stage.sv
// Directed bench for dp_operand_stage: decode fields, forwarding priority, load-use stall,
// PC substitution, hold/flush and asynchronous reset.
module tb_dp_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic [3:0]  rf_raddr_n, rf_raddr_m, rf_raddr_s;
  logic [31:0] rf_rdata_n, rf_rdata_m, rf_rdata_s;
  logic        fwd_ex_valid, fwd_ex_is_load;
  logic [3:0]  fwd_ex_addr;
  logic [31:0] fwd_ex_data;
  logic        fwd_wb_valid;
  logic [3:0]  fwd_wb_addr;
  logic [31:0] fwd_wb_data;
  logic        out_valid, out_ready;
  logic [3:0]  out_cond, out_opcode, out_rd;
  logic        out_set_flags, out_illegal;
  logic [31:0] out_rn_data;
  logic        sh_enable;
  logic [31:0] sh_in_data;
  logic [7:0]  sh_in_data_imm;
  logic        sh_imm_or_reg;
  logic [2:0]  sh_shift_control;
  logic [4:0]  sh_shift_amt_imm;
  logic [31:0] sh_shift_amt_reg;
  logic [3:0]  sh_rotation_code;

  logic [31:0] regs [16];
  int checks = 0;
  int errors = 0;

  assign rf_rdata_n = regs[rf_raddr_n];
  assign rf_rdata_m = regs[rf_raddr_m];
  assign rf_rdata_s = regs[rf_raddr_s];

  always #5 clk = ~clk;

  dp_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .rf_raddr_n(rf_raddr_n), .rf_raddr_m(rf_raddr_m), .rf_raddr_s(rf_raddr_s),
    .rf_rdata_n(rf_rdata_n), .rf_rdata_m(rf_rdata_m), .rf_rdata_s(rf_rdata_s),
    .fwd_ex_valid(fwd_ex_valid), .fwd_ex_is_load(fwd_ex_is_load),
    .fwd_ex_addr(fwd_ex_addr), .fwd_ex_data(fwd_ex_data),
    .fwd_wb_valid(fwd_wb_valid), .fwd_wb_addr(fwd_wb_addr), .fwd_wb_data(fwd_wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_cond(out_cond),
    .out_opcode(out_opcode), .out_set_flags(out_set_flags), .out_rd(out_rd),
    .out_rn_data(out_rn_data), .out_illegal(out_illegal), .sh_enable(sh_enable),
    .sh_in_data(sh_in_data), .sh_in_data_imm(sh_in_data_imm),
    .sh_imm_or_reg(sh_imm_or_reg), .sh_shift_control(sh_shift_control),
    .sh_shift_amt_imm(sh_shift_amt_imm), .sh_shift_amt_reg(sh_shift_amt_reg),
    .sh_rotation_code(sh_rotation_code)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; in_instr = 32'hE0821203; in_pc = 32'h200;
    flush = 1'b0; out_ready = 1'b1;
    fwd_ex_valid = 1'b0; fwd_ex_is_load = 1'b0; fwd_ex_addr = 4'h0; fwd_ex_data = 32'h0;
    fwd_wb_valid = 1'b0; fwd_wb_addr = 4'h0; fwd_wb_data = 32'h0;
    for (int i = 0; i < 16; i++) regs[i] = 32'h1000 + i;

    // reset state, even with a valid instruction presented across an edge
    edge_sample();
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_sh_enable", {31'b0, sh_enable}, 32'h0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'h0);
    chk("rst_sh_in_data", sh_in_data, 32'h0);
    chk("rst_rn_data", out_rn_data, 32'h0);

    // ADD r1,r2,r3,LSL #4
    @(negedge clk);
    rst_n = 1'b1; regs[2] = 32'd5; regs[3] = 32'd1;
    #1;
    chk("t1_in_ready", {31'b0, in_ready}, 32'h1);
    chk("t1_raddr_n", {28'b0, rf_raddr_n}, 32'h2);
    chk("t1_raddr_m", {28'b0, rf_raddr_m}, 32'h3);
    edge_sample();
    chk("t1_out_valid", {31'b0, out_valid}, 32'h1);
    chk("t1_sh_enable", {31'b0, sh_enable}, 32'h1);
    chk("t1_shift_ctl", {29'b0, sh_shift_control}, 32'h0);
    chk("t1_amt_imm", {27'b0, sh_shift_amt_imm}, 32'h4);
    chk("t1_sh_in_data", sh_in_data, 32'h1);
    chk("t1_rn_data", out_rn_data, 32'h5);
    chk("t1_rd", {28'b0, out_rd}, 32'h1);
    chk("t1_opcode", {28'b0, out_opcode}, 32'h4);
    chk("t1_cond", {28'b0, out_cond}, 32'hE);
    chk("t1_illegal", {31'b0, out_illegal}, 32'h0);

    // MOV r0,r1,ROR r2, back-to-back with the previous instruction
    @(negedge clk);
    in_instr = 32'hE1A00271; regs[1] = 32'h77; regs[2] = 32'h123;
    edge_sample();
    chk("t2_out_valid", {31'b0, out_valid}, 32'h1);
    chk("t2_shift_ctl", {29'b0, sh_shift_control}, 32'h7);
    chk("t2_amt_reg", sh_shift_amt_reg, 32'h23);
    chk("t2_sh_in_data", sh_in_data, 32'h77);
    chk("t2_opcode", {28'b0, out_opcode}, 32'hD);
    chk("t2_rotation", {28'b0, sh_rotation_code}, 32'h2);
    chk("t2_imm8", {24'b0, sh_in_data_imm}, 32'h71);

    // EX forwarding has priority over WB
    @(negedge clk);
    in_instr = 32'hE0821203; regs[2] = 32'd5;
    fwd_ex_valid = 1'b1; fwd_ex_addr = 4'h3; fwd_ex_data = 32'hAA;
    fwd_wb_valid = 1'b1; fwd_wb_addr = 4'h3; fwd_wb_data = 32'hBB;
    edge_sample();
    chk("t3_ex_prio", sh_in_data, 32'hAA);
    chk("t3_rn_unfwd", out_rn_data, 32'h5);
    @(negedge clk);
    fwd_ex_valid = 1'b0;
    edge_sample();
    chk("t3_wb_fwd", sh_in_data, 32'hBB);

    // load-use stall on Rm, then capture with WB data
    @(negedge clk);
    fwd_ex_valid = 1'b1; fwd_ex_is_load = 1'b1; fwd_ex_addr = 4'h3; fwd_wb_valid = 1'b0;
    #1;
    chk("t4_stall_ready", {31'b0, in_ready}, 32'h0);
    edge_sample();
    chk("t4_bubble", {31'b0, out_valid}, 32'h0);
    @(negedge clk);
    fwd_ex_valid = 1'b0; fwd_ex_is_load = 1'b0;
    fwd_wb_valid = 1'b1; fwd_wb_addr = 4'h3; fwd_wb_data = 32'hCC;
    #1;
    chk("t4_ready_again", {31'b0, in_ready}, 32'h1);
    edge_sample();
    chk("t4_valid", {31'b0, out_valid}, 32'h1);
    chk("t4_wb_data", sh_in_data, 32'hCC);

    // load to an unused Rn (MOV) must not stall
    @(negedge clk);
    in_instr = 32'hE1A00271; fwd_wb_valid = 1'b0;
    fwd_ex_valid = 1'b1; fwd_ex_is_load = 1'b1; fwd_ex_addr = 4'h0;
    #1;
    chk("t4_mov_no_stall", {31'b0, in_ready}, 32'h1);
    edge_sample();
    chk("t4_mov_valid", {31'b0, out_valid}, 32'h1);

    // r15 as Rm: register-shift form, EX write to r15 must be ignored
    @(negedge clk);
    fwd_ex_is_load = 1'b0; fwd_ex_addr = 4'hF; fwd_ex_data = 32'hDEAD;
    in_instr = 32'hE082131F; in_pc = 32'h100;
    edge_sample();
    chk("t5_pc_rs", sh_in_data, 32'h10C);
    chk("t5_shift_ctl", {29'b0, sh_shift_control}, 32'h1);
    chk("t5_amt_reg", sh_shift_amt_reg, 32'h1);
    @(negedge clk);
    in_instr = 32'hE082100F;
    edge_sample();
    chk("t5_pc_imm", sh_in_data, 32'h108);
    chk("t5_amt_imm0", {27'b0, sh_shift_amt_imm}, 32'h0);

    // hold with out_ready low, then flush
    @(negedge clk);
    fwd_ex_valid = 1'b0; in_instr = 32'hE0821203; in_pc = 32'h200;
    regs[2] = 32'd5; regs[3] = 32'd1;
    edge_sample();
    chk("t6_captured", {31'b0, out_valid}, 32'h1);
    @(negedge clk);
    out_ready = 1'b0; in_instr = 32'hE1A00271;
    #1;
    chk("t6_hold_ready", {31'b0, in_ready}, 32'h0);
    for (int c = 0; c < 3; c++) begin
      edge_sample();
      chk("t6_hold_valid", {31'b0, out_valid}, 32'h1);
      chk("t6_hold_data", sh_in_data, 32'h1);
      chk("t6_hold_rn", out_rn_data, 32'h5);
      chk("t6_hold_ctl", {29'b0, sh_shift_control}, 32'h0);
    end
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("t6_flush_ready", {31'b0, in_ready}, 32'h0);
    edge_sample();
    chk("t6_flush_valid", {31'b0, out_valid}, 32'h0);

    // async reset while holding
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b1; in_instr = 32'hE0821203;
    edge_sample();
    chk("t6_recapture", {31'b0, out_valid}, 32'h1);
    @(negedge clk);
    out_ready = 1'b0;
    edge_sample();
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_arst_valid", {31'b0, out_valid}, 32'h0);
    chk("t6_arst_data", sh_in_data, 32'h0);
    chk("t6_arst_rn", out_rn_data, 32'h0);
    chk("t6_arst_ready", {31'b0, in_ready}, 32'h0);

    // illegal (non data-processing) instruction still flows with valid
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1; in_instr = 32'hE4000000;
    edge_sample();
    chk("t7_valid", {31'b0, out_valid}, 32'h1);
    chk("t7_illegal", {31'b0, out_illegal}, 32'h1);
    @(negedge clk);
    in_valid = 1'b0;
    edge_sample();
    chk("t7_bubble", {31'b0, out_valid}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
